sti_dac_banked: RTL and testbench

Parametrised serial-transmit / DAC-memory writer, and the successor of the fixed 16-bit, 4+4-bank transmitter.
- Accepts parallel words under a load/ready handshake and serialises each as a length-selectable frame on `so_data`/`so_valid`.
- Reassembles the serial stream into pixels and writes them to BANKS odd and BANKS even memories, in linear or checkerboard order.
- On the last word (`pi_end`), zero-fills every remaining pixel slot, then pulses `oem_finish`.

---
 rtl/sti_dac_banked.sv | 199 +++++++++++++++++++
 tb/tb_sti_dac_banked.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sti_dac_banked.sv
`default_nettype none
// ============================================================================
// Module : sti_dac_banked
// Serialises parallel words into length-selectable frames and reassembles the
// bit stream into pixels written across odd/even banked DAC memories.
// Rev    : 1.0
// ============================================================================
module sti_dac_banked #(
  parameter  int DATA_W  = 16,
  parameter  int LEN_W   = 2,
  parameter  int PIX_W   = 8,
  parameter  int BANKS   = 4,
  parameter  int DEPTH   = 32,
  parameter  int ROW_PIX = 8,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [LEN_W-1:0]  pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
  input  logic              pi_mode,
  output logic              pi_ready,
  output logic              so_data,
  output logic              so_valid,
  output logic [PIX_W-1:0]  oem_dataout,
  output logic [ADDR_W-1:0] oem_addr,
  output logic [BANKS-1:0]  odd_wr,
  output logic [BANKS-1:0]  even_wr,
  output logic              oem_finish
);
  localparam int FRAME_W = 8 << LEN_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int SLOTS   = 2 * BANKS * DEPTH;
  localparam int P_W     = $clog2(SLOTS);
  localparam int PC_W    = $clog2(PIX_W + 1);
  localparam int ROW_LOG = $clog2(ROW_PIX);

  localparam logic [CNT_W-1:0] C_DATA_W   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] C_FRAME_W  = CNT_W'(FRAME_W);
  localparam logic [PC_W-1:0]  C_PIX_W    = PC_W'(PIX_W);
  localparam logic [PC_W-1:0]  C_PIX_LAST = PC_W'(PIX_W - 1);
  localparam logic [P_W-1:0]   C_P_LAST   = P_W'(SLOTS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [FRAME_W-1:0]  r_shreg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_msb, r_end, r_mode;
  logic [PIX_W-1:0]    r_pix;
  logic [PC_W-1:0]     r_pcnt;
  logic [P_W-1:0]      r_p;
  logic [PIX_W-1:0]    r_dout;
  logic [ADDR_W-1:0]   r_addr;
  logic [BANKS-1:0]    r_odd_wr, r_even_wr;

  logic [CNT_W-1:0]    w_len;
  logic [FRAME_W-1:0]  w_data_ext, w_mask, w_frame, w_shreg;
  logic                w_bit, w_pix_done, w_capture, w_wr, w_parity;
  logic [PIX_W-1:0]    w_pix_full, w_pix_pad, w_wr_pix;
  logic [P_W-1:0]      w_idx;
  logic [BANKS-1:0]    w_strobe;

  // Frame is pre-aligned so SHIFT always pops from one fixed end of r_shreg.
  always_comb begin
    w_len      = CNT_W'({({1'b0, pi_length} + 1'b1), 3'b000});
    w_data_ext = FRAME_W'(pi_data);
    w_mask     = ~({FRAME_W{1'b1}} << w_len);
    if (w_len > C_DATA_W)
      w_frame = pi_fill ? (w_data_ext << (w_len - C_DATA_W)) : w_data_ext;
    else if (w_len < C_DATA_W)
      w_frame = pi_low ? (w_data_ext & w_mask) : (w_data_ext >> (C_DATA_W - w_len));
    else
      w_frame = w_data_ext;
    w_shreg = pi_msb ? (w_frame << (C_FRAME_W - w_len)) : w_frame;
  end

  assign w_bit      = r_msb ? r_shreg[FRAME_W-1] : r_shreg[0];
  assign w_pix_full = (r_pix << 1) | PIX_W'(w_bit);
  assign w_pix_pad  = r_pix << (C_PIX_W - r_pcnt);
  assign w_pix_done = (r_pcnt == C_PIX_LAST);
  assign w_idx      = r_p >> 1;
  assign w_strobe   = BANKS'(1) << (w_idx >> ADDR_W);
  assign w_parity   = r_p[0] ^ (r_mode & r_p[ROW_LOG]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_wr        = 1'b0;
    w_wr_pix    = w_pix_full;
    pi_ready    = 1'b0;
    so_valid    = 1'b0;
    oem_finish  = 1'b0;
    case (r_state)
      IDLE: begin
        pi_ready = 1'b1;
        if (load) begin
          w_capture   = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        so_valid = 1'b1;
        w_wr     = w_pix_done;
        if (r_cnt == CNT_W'(1))
          w_state_nxt = r_end ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (r_pcnt != '0) begin
          w_wr     = 1'b1;
          w_wr_pix = w_pix_pad;
        end else if (r_p != '0) begin
          w_wr     = 1'b1;
          w_wr_pix = '0;
        end else begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        oem_finish  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign so_data = so_valid & w_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_msb     <= 1'b0;
      r_end     <= 1'b0;
      r_mode    <= 1'b0;
      r_pix     <= '0;
      r_pcnt    <= '0;
      r_p       <= '0;
      r_dout    <= '0;
      r_addr    <= '0;
      r_odd_wr  <= '0;
      r_even_wr <= '0;
    end else begin
      r_odd_wr  <= '0;
      r_even_wr <= '0;
      if (w_capture) begin
        r_shreg <= w_shreg;
        r_cnt   <= w_len;
        r_msb   <= pi_msb;
        r_end   <= pi_end;
        r_mode  <= pi_mode;
      end
      if (r_state == SHIFT) begin
        r_shreg <= r_msb ? (r_shreg << 1) : (r_shreg >> 1);
        r_cnt   <= r_cnt - CNT_W'(1);
        if (w_pix_done) begin
          r_pix  <= '0;
          r_pcnt <= '0;
        end else begin
          r_pix  <= w_pix_full;
          r_pcnt <= r_pcnt + PC_W'(1);
        end
      end
      if (r_state == FLUSH) begin
        r_pix  <= '0;
        r_pcnt <= '0;
      end
      if (w_wr) begin
        if (w_parity) r_even_wr <= w_strobe;
        else          r_odd_wr  <= w_strobe;
        r_dout <= w_wr_pix;
        r_addr <= w_idx[ADDR_W-1:0];
        r_p    <= (r_p == C_P_LAST) ? '0 : r_p + P_W'(1);
      end
      if (r_state == DONE) begin
        r_p    <= '0;
        r_pix  <= '0;
        r_pcnt <= '0;
      end
    end
  end

  assign oem_dataout = r_dout;
  assign oem_addr    = r_addr;
  assign odd_wr      = r_odd_wr;
  assign even_wr     = r_even_wr;

endmodule
`default_nettype wire

// File: tb/tb_sti_dac_banked.sv
`default_nettype none
// ============================================================================
// Module : tb_sti_dac_banked
// Directed self-checking bench for sti_dac_banked (8-bit and 16-bit pixels).
// Rev    : 1.0
// ============================================================================
module tb_sti_dac_banked;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0, load16 = 1'b0;
  logic [15:0] pi_data = '0;
  logic [1:0]  pi_length = '0;
  logic        pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0, pi_mode = 1'b0;

  logic        pi_ready, so_data, so_valid, oem_finish;
  logic [7:0]  oem_dataout;
  logic [4:0]  oem_addr;
  logic [3:0]  odd_wr, even_wr;

  logic        ready16, sdata16, svalid16, finish16;
  logic [15:0] dout16;
  logic [4:0]  addr16;
  logic [3:0]  odd16, even16;

  int          n_tests = 0, n_fail = 0, n_multi = 0, fin_cnt = 0, fin_cyc = 0, cyc = 0;
  logic [20:0] wq[$];
  int          wc[$];
  logic [28:0] q16[$];

  sti_dac_banked dut (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end), .pi_mode(pi_mode),
    .pi_ready(pi_ready), .so_data(so_data), .so_valid(so_valid), .oem_dataout(oem_dataout),
    .oem_addr(oem_addr), .odd_wr(odd_wr), .even_wr(even_wr), .oem_finish(oem_finish)
  );

  sti_dac_banked #(.PIX_W(16)) dut16 (
    .clk(clk), .reset(reset), .load(load16), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end), .pi_mode(pi_mode),
    .pi_ready(ready16), .so_data(sdata16), .so_valid(svalid16), .oem_dataout(dout16),
    .oem_addr(addr16), .odd_wr(odd16), .even_wr(even16), .oem_finish(finish16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (odd_wr != '0 || even_wr != '0) begin
      wq.push_back({odd_wr, even_wr, oem_addr, oem_dataout});
      wc.push_back(cyc);
      if ($countones({odd_wr, even_wr}) != 1) n_multi++;
    end
    if (oem_finish) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
    if (odd16 != '0 || even16 != '0) q16.push_back({odd16, even16, addr16, dout16});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill, input logic msb,
                      input logic low, input logic e, input logic mode,
                      output logic [31:0] bits, output int nb);
    pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb;
    pi_low = low; pi_end = e; pi_mode = mode; load = 1'b1;
    tick();
    load = 1'b0;
    bits = '0;
    nb   = 0;
    while (so_valid && nb < 40) begin
      bits = {bits[30:0], so_data};
      nb++;
      tick();
    end
  endtask

  initial begin
    logic [31:0] bits;
    int          nb;
    int          last;
    logic [7:0]  zor;

    // Reset state
    #3 reset = 1'b0;
    #1;
    check("rst_ready",  32'(pi_ready), 32'd1);
    check("rst_valid",  32'(so_valid), 32'd0);
    check("rst_sdata",  32'(so_data), 32'd0);
    check("rst_odd",    32'(odd_wr), 32'd0);
    check("rst_even",   32'(even_wr), 32'd0);
    check("rst_data",   32'(oem_dataout), 32'd0);
    check("rst_addr",   32'(oem_addr), 32'd0);
    check("rst_finish", 32'(oem_finish), 32'd0);
    #2 reset = 1'b1;
    tick(); tick();

    // MSB-first 8-bit frame from the low byte
    send(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, bits, nb);
    check("msb_bits",  bits, 32'h0000_00C3);
    check("msb_nbits", 32'(nb), 32'd8);
    check("msb_odd",   32'(odd_wr), 32'h1);
    check("msb_even",  32'(even_wr), 32'h0);
    check("msb_addr",  32'(oem_addr), 32'd0);
    check("msb_data",  32'(oem_dataout), 32'hC3);

    // LSB-first: C3 is a bit palindrome, lands at P=1
    send(16'hA5C3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, bits, nb);
    check("lsb_bits",  bits, 32'h0000_00C3);
    check("lsb_even",  32'(even_wr), 32'h1);
    check("lsb_odd",   32'(odd_wr), 32'h0);
    check("lsb_addr",  32'(oem_addr), 32'd0);
    check("lsb_data",  32'(oem_dataout), 32'hC3);

    // load during SHIFT is ignored; word lands at P=2 -> odd0 addr1
    pi_data = 16'h005A; pi_length = 2'd0; pi_low = 1'b1; pi_msb = 1'b1;
    pi_end = 1'b0; pi_mode = 1'b0; load = 1'b1;
    tick();
    pi_data = 16'h00FF;
    for (int i = 0; i < 3; i++) begin
      check("busy_ready", 32'(pi_ready), 32'd0);
      tick();
    end
    load = 1'b0;
    for (int i = 0; i < 20 && so_valid; i++) tick();
    check("hs_odd",  32'(odd_wr), 32'h1);
    check("hs_addr", 32'(oem_addr), 32'd1);
    check("hs_data", 32'(oem_dataout), 32'h5A);
    tick();
    check("hs_no_recapture", 32'(so_valid), 32'd0);

    // Asynchronous reset in the middle of a frame
    pi_data = 16'h00AA; load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(so_valid), 32'd0);
    check("mid_rst_ready", 32'(pi_ready), 32'd1);
    check("mid_rst_data",  32'(oem_dataout), 32'd0);
    check("mid_rst_addr",  32'(oem_addr), 32'd0);
    #2 reset = 1'b1;
    wq.delete(); wc.delete();
    repeat (12) tick();
    check("post_rst_writes", 32'(wq.size()), 32'd0);
    check("post_rst_valid",  32'(so_valid), 32'd0);

    // 32-bit frame, zero-extended, restarting at P=0
    send(16'h1234, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bits, nb);
    tick();
    check("zx_nbits", 32'(nb), 32'd32);
    check("zx_bits",  bits, 32'h0000_1234);
    check("zx_count", 32'(wq.size()), 32'd4);
    check("zx_w0", 32'(wq[0]), 32'({4'b0001, 4'b0000, 5'd0, 8'h00}));
    check("zx_w1", 32'(wq[1]), 32'({4'b0000, 4'b0001, 5'd0, 8'h00}));
    check("zx_w2", 32'(wq[2]), 32'({4'b0001, 4'b0000, 5'd1, 8'h12}));
    check("zx_w3", 32'(wq[3]), 32'({4'b0000, 4'b0001, 5'd1, 8'h34}));

    // Checkerboard: nine back-to-back words at P=4..12
    wq.delete(); wc.delete();
    for (int k = 0; k < 9; k++) begin
      check("b2b_ready", 32'(pi_ready), 32'd1);
      send({8'hEE, 8'(8'h10 + k)}, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, bits, nb);
    end
    tick();
    check("cb_count", 32'(wq.size()), 32'd9);
    check("cb_p4",  32'(wq[0]), 32'({4'b0001, 4'b0000, 5'd2, 8'h10}));
    check("cb_p8",  32'(wq[4]), 32'({4'b0000, 4'b0001, 5'd4, 8'h14}));
    check("cb_p9",  32'(wq[5]), 32'({4'b0001, 4'b0000, 5'd4, 8'h15}));
    check("cb_p12", 32'(wq[8]), 32'({4'b0000, 4'b0001, 5'd6, 8'h18}));

    // Flush from P=0: one data write then 255 zero writes
    reset = 1'b0;
    #1 reset = 1'b1;
    tick();
    wq.delete(); wc.delete(); fin_cnt = 0;
    send(16'h0077, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, bits, nb);
    for (int i = 0; i < 400 && !oem_finish; i++) tick();
    check("fl_finish",    32'(oem_finish), 32'd1);
    check("fl_ready_low", 32'(pi_ready), 32'd0);
    tick();
    check("fl_finish_pulse", 32'(oem_finish), 32'd0);
    check("fl_ready_back",   32'(pi_ready), 32'd1);
    last = wq.size() - 1;
    zor  = '0;
    for (int i = 1; i < wq.size(); i++) zor |= wq[i][7:0];
    check("fl_count",   32'(wq.size()), 32'd256);
    check("fl_first",   32'(wq[0]), 32'({4'b0001, 4'b0000, 5'd0, 8'h77}));
    check("fl_last",    32'(wq[last]), 32'({4'b0000, 4'b1000, 5'd31, 8'h00}));
    check("fl_zeros",   32'(zor), 32'd0);
    check("fl_consec",  32'(wc[last] - wc[0]), 32'd255);
    check("fl_fin_cnt", 32'(fin_cnt), 32'd1);
    check("fl_fin_cyc", 32'(fin_cyc), 32'(wc[last] + 1));
    check("one_hot",    32'(n_multi), 32'd0);

    // 16-bit pixels: 24-bit frame leaves a half pixel for flush to pad
    q16.delete();
    pi_data = 16'hABCD; pi_length = 2'd2; pi_fill = 1'b0; pi_msb = 1'b1;
    pi_low = 1'b0; pi_end = 1'b1; pi_mode = 1'b0; load16 = 1'b1;
    tick();
    load16 = 1'b0;
    for (int i = 0; i < 600 && !finish16; i++) tick();
    check("p16_finish", 32'(finish16), 32'd1);
    check("p16_count",  32'(q16.size()), 32'd256);
    check("p16_w0", 32'(q16[0]), 32'({4'b0001, 4'b0000, 5'd0, 16'h00AB}));
    check("p16_w1", 32'(q16[1]), 32'({4'b0000, 4'b0001, 5'd0, 16'hCD00}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
